// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the sequential IEEE-754 add/sub controller.
//   EXP_W_DEF / MAN_W_DEF : default exponent and stored-mantissa widths (binary32)
//   EXP_MAX               : all-ones exponent for the default format
//   QNAN                  : canonical quiet NaN for the default format
//   state_t               : controller state encoding
package fp_addsub_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;
  localparam logic [EXP_W_DEF+MAN_W_DEF:0] QNAN =
    {1'b0, EXP_MAX, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/fp_special_case.sv
// Combinational operand classifier.
//   a, b      : packed operands {sign, exp, man} (b already carries the op-adjusted sign)
//   a_zero/b_zero : exponent is zero (denormals are treated as zero)
//   a_inf/b_inf   : exponent all-ones, mantissa zero
//   a_nan/b_nan   : exponent all-ones, mantissa non-zero
//   spec_res      : result word when either operand has an all-ones exponent
module fp_special_case
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 a_zero,
  output logic                 a_inf,
  output logic                 a_nan,
  output logic                 b_zero,
  output logic                 b_inf,
  output logic                 b_nan,
  output logic [EXP_W+MAN_W:0] spec_res
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0] NAN_WORD = (W == $bits(QNAN)) ? W'(QNAN) :
                                      {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EONES) && (ma == '0);
  assign b_inf  = (eb == EONES) && (mb == '0);
  assign a_nan  = (ea == EONES) && (ma != '0);
  assign b_nan  = (eb == EONES) && (mb != '0);

  always_comb begin
    spec_res = NAN_WORD;
    // Opposite-signed infinities cancel into NaN; otherwise the infinity wins.
    if (a_nan || b_nan || (a_inf && b_inf && (a[W-1] ^ b[W-1])))
      spec_res = NAN_WORD;
    else if (a_inf)
      spec_res = {a[W-1], EONES, {MAN_W{1'b0}}};
    else
      spec_res = {b[W-1], EONES, {MAN_W{1'b0}}};
  end
endmodule

// File: rtl/fp_addsub_seq_ctrl.sv
// Multi-cycle IEEE-754 adder/subtractor sequencer (one operation in flight).
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake; in_ready high only in IDLE
//   a, b, op          : operands {sign,exp,man}; op=1 computes a-b
//   out_valid/out_ready : result handshake; result held while out_valid=1
//   result            : packed result (truncating, denormals flushed)
//   busy              : high whenever the controller is not IDLE
module fp_addsub_seq_ctrl
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EONES   = '1;
  localparam logic [EXP_W-1:0] E_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] EMAX_M1 = EONES - E_ONE;
  localparam logic [EXP_W-1:0] BIG_D   = EXP_W'(MAN_W + 2);

  function automatic logic [W-1:0] sat_inf(input logic s);
    return {s, EONES, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] flush_zero(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  state_t           state, state_nx;
  logic [W-1:0]     ra, rb, res_q;
  logic             sx, sy, big;
  logic [EXP_W-1:0] ex, d;
  logic [MAN_W:0]   mx, my;
  logic [MAN_W+1:0] sm;

  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [W-1:0]     spec_word;
  logic             special, both_zero, swap;
  logic [EXP_W-1:0] ea, eb, d_cmp;
  logic [MAN_W:0]   ha, hb;
  logic             norm_done;
  logic [W-1:0]     norm_word;

  fp_special_case #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_special (
    .a        (ra),
    .b        (rb),
    .a_zero   (a_zero),
    .a_inf    (a_inf),
    .a_nan    (a_nan),
    .b_zero   (b_zero),
    .b_inf    (b_inf),
    .b_nan    (b_nan),
    .spec_res (spec_word)
  );

  assign ea = ra[W-2 -: EXP_W];
  assign eb = rb[W-2 -: EXP_W];
  // Zero operands contribute no hidden bit, which also flushes denormals.
  assign ha = a_zero ? '0 : {1'b1, ra[MAN_W-1:0]};
  assign hb = b_zero ? '0 : {1'b1, rb[MAN_W-1:0]};

  assign special   = a_inf | a_nan | b_inf | b_nan;
  assign both_zero = a_zero & b_zero;
  assign swap      = {ea, ha} < {eb, hb};
  assign d_cmp     = swap ? (eb - ea) : (ea - eb);

  // One normalisation decision per cycle; norm_word is the final word when done.
  always_comb begin
    norm_done = 1'b1;
    norm_word = {sx, ex, sm[MAN_W-1:0]};
    if (sm[MAN_W+1]) begin
      if (ex == EMAX_M1) norm_word = sat_inf(sx);
      else               norm_done = 1'b0;
    end else if (sm == '0) begin
      norm_word = '0;
    end else if (!sm[MAN_W]) begin
      if (ex == E_ONE) norm_word = flush_zero(sx);
      else             norm_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CMP;
      CMP:     state_nx = (special || both_zero) ? DONE : ALIGN;
      ALIGN:   if (big || (d <= E_ONE)) state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    if (norm_done) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0; rb <= '0; res_q <= '0;
      sx <= 1'b0; sy <= 1'b0; big <= 1'b0;
      ex <= '0; d <= '0; mx <= '0; my <= '0; sm <= '0;
    end else begin
      case (state)
        // Operand capture: the operation is folded into B's sign.
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= {b[W-1] ^ op, b[W-2:0]};
        end
        // Classification and magnitude ordering.
        CMP: begin
          if (special)        res_q <= spec_word;
          else if (both_zero) res_q <= '0;
          else begin
            sx  <= swap ? rb[W-1] : ra[W-1];
            sy  <= swap ? ra[W-1] : rb[W-1];
            ex  <= swap ? eb : ea;
            mx  <= swap ? hb : ha;
            my  <= swap ? ha : hb;
            d   <= d_cmp;
            big <= (d_cmp > BIG_D);
          end
        end
        // Serial alignment; a distance beyond the mantissa clears Y at once.
        ALIGN: begin
          if (big) begin
            my <= '0;
            d  <= '0;
          end else if (d != '0) begin
            my <= my >> 1;
            d  <= d - E_ONE;
          end
        end
        // Magnitude add/sub; |X| >= |Y| keeps the difference non-negative.
        ADD: sm <= (sx ^ sy) ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        // Serial normalisation.
        NORM: begin
          if (norm_done) begin
            res_q <= norm_word;
          end else if (sm[MAN_W+1]) begin
            sm <= sm >> 1;
            ex <= ex + E_ONE;
          end else begin
            sm <= sm << 1;
            ex <= ex - E_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
endmodule

// File: tb/tb_fp_addsub_seq_ctrl.sv
// Directed bench for fp_addsub_seq_ctrl (binary32 defaults).
module tb_fp_addsub_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_addsub_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one operand pair and returns just after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_v; op = top;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid rises.
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic top, input logic [31:0] exp);
    int lat;
    start_op(ta, tb_v, top);
    wait_valid(tag, lat);
    chk(tag, result, exp);
    accept();
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_result",    result,             32'h0);

    // 1.0 + 1.0 with latency
    start_op(32'h3F800000, 32'h3F800000, 1'b0);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    wait_valid("one_plus_one", lat);
    chk("one_plus_one", result, 32'h40000000);
    chk("one_plus_one_lat", 32'(lat), 32'd6);
    accept();
    chk("idle_after_accept", {31'b0, in_ready}, 32'd1);

    do_op("one_minus_075",   32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000);
    do_op("one_minus_one",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    do_op("far_align",       32'h3FC00000, 32'h30800000, 1'b0, 32'h3FC00000);
    do_op("inf_plus_ninf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
    do_op("overflow_inf",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    do_op("swap_neg",        32'h3F400000, 32'h3F800000, 1'b1, 32'hBE800000);
    do_op("nan_in",          32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    do_op("one_minus_inf",   32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    do_op("zero_plus_zero",  32'h80000000, 32'h00000000, 1'b0, 32'h00000000);
    do_op("zero_plus_one",   32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000);
    do_op("one_plus_neg1",   32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);
    do_op("underflow_flush", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000);

    // Backpressure: result held, in_valid ignored while DONE.
    start_op(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid("bp", lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 32'h40400000; b = 32'h40400000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result",    result,             32'h40000000);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
    end
    accept();
    chk("bp_released",    {31'b0, out_valid}, 32'd0);
    chk("bp_result_held", result,             32'h40000000);
    chk("bp_idle",        {31'b0, busy},      32'd0);

    // Reset during ALIGN (d=3) aborts with no output.
    start_op(32'h3F800000, 32'h3E000000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_busy",      {31'b0, busy},      32'd0);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    do_op("after_abort", 32'h3F800000, 32'h3E000000, 1'b0, 32'h3F900000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
